// File: rtl/field_weave_frame_buffer.sv
// Dual-bank raster frame buffer: weaves interlaced fields into full frames and publishes each completed frame by bank swap.
// Latency: a write lands at the edge where pixel_valid=1; a read address presented at edge N gives pixel_out after edge N+2.
// Backpressure: none; one write and one read per cycle. Pixels past the end of a frame/field are dropped and flag overrun.
//
// Ports:
//   clk, reset        single clock; asynchronous active-high reset
//   interlace_mode    0 progressive, 1 interlaced (sampled on frame_start)
//   field_id          0 even-line field, 1 odd-line field (sampled on frame_start)
//   frame_start       one-cycle pulse with the first pixel of a frame/field
//   pixel_valid       pixel_in carries a pixel this cycle
//   pixel_in          raster-order pixel
//   read_addr         linear address row*H_ACTIVE+col into the published frame
//   pixel_out         read data (0 for addresses >= H_ACTIVE*V_ACTIVE)
//   frame_done        one-cycle pulse on a bank swap
//   overrun           sticky, set when a pixel arrives after its frame/field completed
//
// Build option: FRAME_BUFFER_DOUBLE_EN selects two banks. Without it a single
// bank is shared by reader and writer (tearing possible); frame_done, overrun
// and the field pairing logic behave identically.

module field_weave_frame_buffer #(
  parameter int PIXEL_W  = 24,
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               interlace_mode,
  input  logic               field_id,
  input  logic               frame_start,
  input  logic               pixel_valid,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic [ADDR_W-1:0]  read_addr,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               frame_done,
  output logic               overrun
);

  localparam int DEPTH  = H_ACTIVE * V_ACTIVE;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COL_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int ROW_W  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST_P  = ROW_W'(V_ACTIVE - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST_I  = ROW_W'(V_ACTIVE / 2 - 1);
  // Interlaced line end skips the line belonging to the other field.
  localparam logic [MEM_AW-1:0] STEP_LINE_I = MEM_AW'(H_ACTIVE + 1);
  localparam logic [MEM_AW-1:0] STEP_ONE    = MEM_AW'(1);
  // The odd field starts on line 1.
  localparam logic [MEM_AW-1:0] FIELD1_BASE = MEM_AW'(H_ACTIVE);
  // One bit wider so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   RD_LIMIT    = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,    // no frame_start since reset: pixels ignored
    S_ACTIVE,  // frame/field in progress: pixels written
    S_DONE     // frame/field complete: pixels dropped as overrun
  } state_t;

  state_t r_state, w_state_nxt;

  // Write side state
  logic               r_mode;
  logic               r_field;
  logic               r_even_ok;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [MEM_AW-1:0]  r_waddr;
  logic               r_frame_done;
  logic               r_overrun;

  // Read pipeline
  logic [ADDR_W-1:0]  r_raddr;
  logic               r_oor;
  logic [PIXEL_W-1:0] r_rdat;
  logic [PIXEL_W-1:0] r_pixel_out;

  // Effective write position this cycle: a frame_start overrides the counters
  // so the pixel arriving with it lands on address 0 of the new frame/field.
  logic               w_mode;
  logic               w_field;
  logic [COL_W-1:0]   w_col;
  logic [ROW_W-1:0]   w_row;
  logic [MEM_AW-1:0]  w_base;
  logic [MEM_AW-1:0]  w_waddr;
  logic               w_last_col;
  logic               w_last_row;
  logic               w_wr_en;
  logic               w_ovr_evt;
  logic               w_complete;
  logic               w_swap;
  logic               w_raddr_oor;
  logic [MEM_AW-1:0]  w_ridx;

  assign w_mode     = frame_start ? interlace_mode : r_mode;
  assign w_field    = frame_start ? field_id       : r_field;
  assign w_col      = frame_start ? '0 : r_col;
  assign w_row      = frame_start ? '0 : r_row;
  assign w_base     = (interlace_mode && field_id) ? FIELD1_BASE : '0;
  assign w_waddr    = frame_start ? w_base : r_waddr;
  assign w_last_col = (w_col == COL_LAST);
  assign w_last_row = (w_row == (w_mode ? ROW_LAST_I : ROW_LAST_P));

  // ---------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_ovr_evt   = 1'b0;
    w_complete  = 1'b0;
    w_swap      = 1'b0;

    if (frame_start) begin
      w_state_nxt = S_ACTIVE;
    end

    w_wr_en   = pixel_valid && (frame_start || (r_state == S_ACTIVE));
    w_ovr_evt = pixel_valid && !frame_start && (r_state == S_DONE);

    if (w_wr_en && w_last_col && w_last_row) begin
      w_complete  = 1'b1;
      w_state_nxt = S_DONE;
      // A progressive frame always publishes; an odd field publishes only
      // when its even partner completed earlier.
      w_swap = !w_mode || (w_field && r_even_ok);
    end
  end

  // ---------------------------------------------------------------------
  // Write counters, field pairing, status outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode       <= 1'b0;
      r_field      <= 1'b0;
      r_even_ok    <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_waddr      <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (frame_start) begin
        r_mode  <= interlace_mode;
        r_field <= field_id;
      end

      if (w_wr_en) begin
        if (w_last_col) begin
          r_col   <= '0;
          r_row   <= w_row + ROW_W'(1);
          r_waddr <= w_waddr + (w_mode ? STEP_LINE_I : STEP_ONE);
        end else begin
          r_col   <= w_col + COL_W'(1);
          r_row   <= w_row;
          r_waddr <= w_waddr + STEP_ONE;
        end
      end else if (frame_start) begin
        r_col   <= '0;
        r_row   <= '0;
        r_waddr <= w_base;
      end

      // Completing an even field arms the pair; completing an odd field
      // consumes it (or finds it already clear). A new even field disarms.
      if (w_complete && w_mode) begin
        r_even_ok <= !w_field;
      end else if (frame_start && !field_id) begin
        r_even_ok <= 1'b0;
      end

      r_frame_done <= w_swap;

      if (w_ovr_evt) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read address stage: address and range flag registered together
  // ---------------------------------------------------------------------
  assign w_raddr_oor = ({1'b0, r_raddr} >= RD_LIMIT);
  assign w_ridx      = w_raddr_oor ? '0 : r_raddr[MEM_AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_raddr     <= '0;
      r_oor       <= 1'b1;
      r_pixel_out <= '0;
    end else begin
      r_raddr     <= read_addr;
      r_oor       <= w_raddr_oor;
      r_pixel_out <= r_oor ? '0 : r_rdat;
    end
  end

  // ---------------------------------------------------------------------
  // Storage (not reset: contents survive reset)
  // ---------------------------------------------------------------------
`ifdef FRAME_BUFFER_DOUBLE_EN
  logic [PIXEL_W-1:0] r_mem [2][DEPTH];
  logic               r_read_bank;
  logic               r_rsel;
  logic               w_write_bank;

  assign w_write_bank = ~r_read_bank;

  // The bank select is captured alongside the read address, so an address
  // registered on the final-pixel edge still sees the old frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_bank <= 1'b0;
      r_rsel      <= 1'b0;
    end else begin
      r_rsel <= r_read_bank;
      if (w_swap) begin
        r_read_bank <= w_write_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_write_bank][w_waddr] <= pixel_in;
    end
    r_rdat <= r_mem[r_rsel][w_ridx];
  end
`else
  logic [PIXEL_W-1:0] r_mem [DEPTH];

  // Single shared bank: a read issued on the same edge as a write to the
  // same address sees the new pixel, since the array is read one edge later.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_waddr] <= pixel_in;
    end
    r_rdat <= r_mem[w_ridx];
  end
`endif

  assign pixel_out  = r_pixel_out;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_field_weave_frame_buffer.sv
module tb_field_weave_frame_buffer;

  localparam int PW = 24;
  localparam int H  = 4;
  localparam int V  = 4;
  localparam int AW = 5;

`ifdef FRAME_BUFFER_DOUBLE_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  localparam logic [PW-1:0] ZERO = '0;
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic          clk = 1'b0;
  logic          reset;
  logic          interlace_mode;
  logic          field_id;
  logic          frame_start;
  logic          pixel_valid;
  logic [PW-1:0] pixel_in;
  logic [AW-1:0] read_addr;
  logic [PW-1:0] pixel_out;
  logic          frame_done;
  logic          overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  field_weave_frame_buffer #(
    .PIXEL_W (PW),
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .ADDR_W  (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .interlace_mode(interlace_mode),
    .field_id      (field_id),
    .frame_start   (frame_start),
    .pixel_valid   (pixel_valid),
    .pixel_in      (pixel_in),
    .read_addr     (read_addr),
    .pixel_out     (pixel_out),
    .frame_done    (frame_done),
    .overrun       (overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic fs, input logic [PW-1:0] d);
    frame_start = fs;
    pixel_valid = 1'b1;
    pixel_in    = d;
    step();
    frame_start = 1'b0;
    pixel_valid = 1'b0;
  endtask

  task automatic send(input logic mode, input logic fld, input logic [PW-1:0] base, input int n);
    interlace_mode = mode;
    field_id       = fld;
    for (int i = 0; i < n; i++) begin
      pix(i == 0, base + PW'(i));
    end
  endtask

  // Address presented before edge N; result checked after edge N+2.
  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [PW-1:0] exp);
    read_addr = a;
    repeat (3) step();
    chk(tag, pixel_out, exp);
  endtask

  initial begin
    reset          = 1'b1;
    interlace_mode = 1'b0;
    field_id       = 1'b0;
    frame_start    = 1'b0;
    pixel_valid    = 1'b0;
    pixel_in       = '0;
    read_addr      = '0;
    step();
    step();
    chk("rst_pixel_out", pixel_out, ZERO);
    chk("rst_frame_done", PW'(frame_done), ZERO);
    chk("rst_overrun", PW'(overrun), ZERO);
    reset = 1'b0;
    step();

    // Progressive frame 0x00..0x0F
    send(1'b0, 1'b0, 24'h000000, 15);
    chk("prog_fd_before_last", PW'(frame_done), ZERO);
    pix(1'b0, 24'h00000F);
    chk("prog_fd", PW'(frame_done), ONE);
    step();
    chk("prog_fd_one_cycle", PW'(frame_done), ZERO);
    chk("prog_no_overrun", PW'(overrun), ZERO);
    rd("prog_addr5", 5'd5, 24'h000005);
    rd("prog_addr0", 5'd0, 24'h000000);
    rd("prog_addr15", 5'd15, 24'h00000F);

    // Read latency: old result holds for two edges after a new address
    read_addr = 5'd7;
    step();
    chk("lat_edge_n", pixel_out, 24'h00000F);
    step();
    chk("lat_edge_n1", pixel_out, 24'h00000F);
    step();
    chk("lat_edge_n2", pixel_out, 24'h000007);

    rd("oor_addr16", 5'd16, ZERO);

    // Overrun: 17th pixel after a completed frame
    pix(1'b0, 24'h0000EE);
    chk("ovr_set", PW'(overrun), ONE);
    chk("ovr_no_swap", PW'(frame_done), ZERO);
    step();
    step();
    chk("ovr_sticky", PW'(overrun), ONE);
    rd("ovr_no_write", 5'd0, 24'h000000);

    // Abort after 7 pixels, then a full frame
    send(1'b0, 1'b0, 24'h000100, 7);
    chk("abort_no_fd", PW'(frame_done), ZERO);
    rd("abort_addr2", 5'd2, DBL ? 24'h000002 : 24'h000102);
    send(1'b0, 1'b0, 24'h000200, 16);
    chk("after_abort_fd", PW'(frame_done), ONE);
    rd("after_abort_addr6", 5'd6, 24'h000206);
    chk("ovr_across_frames", PW'(overrun), ONE);

    // Interlaced weave, field 1 right after field 0
    send(1'b1, 1'b0, 24'h0000A0, 8);
    chk("weave_f0_no_fd", PW'(frame_done), ZERO);
    send(1'b1, 1'b1, 24'h0000B0, 8);
    chk("weave_fd", PW'(frame_done), ONE);
    step();
    chk("weave_fd_one_cycle", PW'(frame_done), ZERO);
    rd("weave_addr4", 5'd4, 24'h0000B0);
    rd("weave_addr8", 5'd8, 24'h0000A4);
    rd("weave_addr15", 5'd15, 24'h0000B7);
    rd("weave_addr0", 5'd0, 24'h0000A0);

    // Reset in the middle of a progressive frame
    interlace_mode = 1'b0;
    field_id       = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pix(i == 0, 24'h000300 + PW'(i));
    end
    pixel_valid = 1'b1;
    pixel_in    = 24'h000305;
    reset       = 1'b1;
    step();
    chk("midrst_pixel_out", pixel_out, ZERO);
    chk("midrst_frame_done", PW'(frame_done), ZERO);
    chk("midrst_overrun", PW'(overrun), ZERO);
    pixel_valid = 1'b0;
    reset       = 1'b0;
    step();
    rd("midrst_addr6", 5'd6, DBL ? 24'h000206 : 24'h0000B2);
    rd("midrst_addr2", 5'd2, 24'h000302);

    // Odd field without its even partner
    send(1'b1, 1'b1, 24'h0000C0, 8);
    chk("f1only_no_fd", PW'(frame_done), ZERO);
    step();
    chk("f1only_no_fd_next", PW'(frame_done), ZERO);
    rd("f1only_addr4", 5'd4, DBL ? 24'h000304 : 24'h0000C0);
    rd("f1only_addr6", 5'd6, DBL ? 24'h000206 : 24'h0000C2);
    chk("f1only_no_overrun", PW'(overrun), ZERO);

    // Read issued on the same edge as the write of address 3
    interlace_mode = 1'b0;
    field_id       = 1'b0;
    pix(1'b1, 24'h000400);
    pix(1'b0, 24'h000401);
    pix(1'b0, 24'h000402);
    read_addr = 5'd3;
    pix(1'b0, 24'h000403);
    step();
    step();
    chk("tear_addr3", pixel_out, DBL ? 24'h000303 : 24'h000403);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/field_weave_frame_buffer.md
# field_weave_frame_buffer

Parametrised dual-bank frame buffer between the camera/pixel pipeline and the display/pose-analysis readers. It accepts a raster stream in either progressive or interlaced mode. Interlaced fields are woven into full frames. Completed frames are published to a random-access read port by bank swap, so readers never see a partially written frame.

## Interface
- `PIXEL_W`, 24, bits per pixel
- `H_ACTIVE`, 320, pixels per line
- `V_ACTIVE`, 240, lines per frame; must be even
- `ADDR_W`, 17, read address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- `clk`  in  1  single clock for all logic
- `reset`  in  1  asynchronous, active-high reset
- `interlace_mode`  in  1  0 = progressive frames, 1 = interlaced fields; sampled on `frame_start`
- `field_id`  in  1  0 = even-line field, 1 = odd-line field; sampled on `frame_start`
- `frame_start`  in  1  one-cycle pulse; marks the first pixel of a frame or field
- `pixel_valid`  in  1  `pixel_in` is valid this cycle
- `pixel_in`  in  PIXEL_W  raster-order pixel
- `read_addr`  in  ADDR_W  linear address, row*H_ACTIVE+col, of the published frame
- `pixel_out`  out  PIXEL_W  read data
- `frame_done`  out  1  one-cycle pulse when a bank swap occurs
- `overrun`  out  1  sticky; set when a pixel arrives after its frame/field is complete

## Operation
- Storage is two banks of H_ACTIVE*V_ACTIVE words. One bank is the write bank; the other is the read bank.
- Write counters: `col` runs 0..H_ACTIVE-1; `row` runs 0..R-1.
  - R = V_ACTIVE in progressive mode.
  - R = V_ACTIVE/2 in interlaced mode.
- Write address:
  - progressive: row*H_ACTIVE+col
  - interlaced: (2*row+field)*H_ACTIVE+col
  - Implemented incrementally: +1 within a line; at end of line, +1 (progressive) or +H_ACTIVE+1 (interlaced).
- On `frame_start`:
  - mode and field are latched;
  - counters clear;
  - any partially written frame/field is abandoned with no swap;
  - `pixel_valid` in the same cycle writes address 0 of the new frame/field.
- A `pixel_valid` with no `frame_start` since reset is ignored.
- Progressive completion: the write of the last pixel (row R-1, col H_ACTIVE-1) triggers a swap.
- Interlaced completion:
  - Completing field 0 sets `even_ok`.
  - Completing field 1 with `even_ok` set triggers a swap and clears `even_ok`.
  - Completing field 1 without `even_ok` produces no swap and no `frame_done`.
  - A `frame_start` with `field_id`=0 clears `even_ok`.
- Swap: write and read banks exchange, and `frame_done` pulses for one cycle.
- After completion, further `pixel_valid` before the next `frame_start`: the pixel is dropped and `overrun` is set. Only `reset` clears `overrun`.
- Read: `read_addr` and the current read-bank select are registered together. An out-of-range address (>= H_ACTIVE*V_ACTIVE) returns 0.
- Reset:
  - `pixel_out`=0, `frame_done`=0, `overrun`=0;
  - read bank 0, write bank 1;
  - counters 0, `even_ok`=0, no frame active.
  - Memory contents are not cleared.
- Reset mid-frame discards the partial frame. The read bank returns to bank 0.

## Timing
- Write: a pixel is stored at the clock edge where `pixel_valid`=1.
- Read latency is 2 cycles: address presented at edge N; `pixel_out` is valid after edge N+2 and holds until the next read result.
- `frame_done` is asserted in the cycle after the edge that wrote the final pixel.
- The bank select changes at that same edge:
  - a read address registered at the final-pixel edge uses the old bank;
  - addresses registered from the following edge use the new bank.
- Simultaneous `frame_start` and the final pixel of the previous frame cannot occur (the final pixel carries no `frame_start`). A `frame_start` in the cycle after the final pixel is legal; no gap cycles are required.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- `FRAME_BUFFER_DOUBLE_EN` defined: dual-bank behaviour as above.
- Not defined:
  - only one bank is instantiated;
  - reads and writes share it, so tearing is allowed;
  - the "swap" event still pulses `frame_done` with identical timing;
  - `overrun` and `even_ok` logic are unchanged.

## Test plan
All scenarios use H_ACTIVE=4, V_ACTIVE=4.
- Reset check: assert `reset` mid-stream → `pixel_out`=0, `frame_done`=0, `overrun`=0 next cycle; after release, reading any address returns the old bank-0 contents with 2-cycle latency.
- Progressive frame: `frame_start`, then 16 pixels 0x000000..0x00000F → `frame_done` one cycle after the 16th write; reading addr 5 returns 0x000005 two cycles later.
- Interlaced weave: field 0 pixels 0xA0..0xA7, then field 1 pixels 0xB0..0xB7 → one `frame_done` after field 1 only; addr 4 = 0xB0, addr 8 = 0xA4, addr 15 = 0xB7.
- Field 1 without field 0: after reset, send only field 1 → no `frame_done`; reads unchanged.
- Overrun and abort:
  - a 17th pixel after a completed progressive frame → `overrun`=1 and stays set; no memory write;
  - a `frame_start` after 7 pixels → no swap, and the next full frame swaps normally.
- Boundary read: `read_addr`=16 → `pixel_out`=0. With `FRAME_BUFFER_DOUBLE_EN` undefined, a read during the write of addr 3 returns the new data two cycles later.
